// File: rtl/stopwatch_bcd.sv
// -----------------------------------------------------------------------------
// stopwatch_bcd
// Centisecond stopwatch (SS.cc) that drives a four-digit seven-segment scan
// driver. The raw run/stop and clear buttons are synchronised, debounced and
// edge-detected here. Time is kept as four cascaded BCD digits that advance on
// a prescaled 100 Hz tick.
//
// Parameters
//   CLK_DIV   CLK cycles per 10 ms tick
//   DEBOUNCE  CLK cycles a synchronised level must stay stable to be accepted
//   BLANK_LZ  when 1, segData_1 shows code 12 (blank) while tens-of-seconds is 0
//
// Ports
//   CLK        in   system clock, rising edge
//   RST        in   synchronous active-high reset
//   btnRun     in   raw run/stop button (asynchronous)
//   btnClr     in   raw clear button (asynchronous)
//   segData_1  out  tens of seconds (0-9, or 12 when blanked)
//   segData_2  out  units of seconds (0-9)
//   segData_3  out  tenths (0-9)
//   segData_4  out  hundredths (0-9)
//   running    out  high while in RUN
//   ovf        out  sticky flag, set on the 99.99 -> 00.00 wrap
// -----------------------------------------------------------------------------
module stopwatch_bcd #(
   parameter int CLK_DIV  = 250000,
   parameter int DEBOUNCE = 250000,
   parameter bit BLANK_LZ = 1'b1
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       btnRun,
   input  logic       btnClr,
   output logic [3:0] segData_1,
   output logic [3:0] segData_2,
   output logic [3:0] segData_3,
   output logic [3:0] segData_4,
   output logic       running,
   output logic       ovf
);

   localparam int DB_W = $clog2(DEBOUNCE + 1);
   localparam int PS_W = $clog2(CLK_DIV + 1);
   localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE - 1);
   localparam logic [PS_W-1:0] PS_MAX = PS_W'(CLK_DIV - 1);
   localparam logic [3:0] BLANK_CODE = 4'd12;
   localparam logic [3:0] RST_SEG1   = BLANK_LZ ? 4'd12 : 4'd0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } state_t;

   // Index 0 is the run/stop button, index 1 the clear button.
   logic [1:0]      btnRaw_s;
   logic [1:0]      sync1_r;
   logic [1:0]      sync2_r;
   logic [1:0]      accLevel_r;
   logic [1:0]      pulse_r;
   logic [DB_W-1:0] dbCnt_r [2];

   state_t          state_r;
   logic [PS_W-1:0] presc_r;
   logic            ovf_r;
   logic            runP_s;
   logic            clrP_s;
   logic            tick_s;
   logic            zero_s;
   logic            wrap_s;

   logic [3:0] tens_r,  units_r,  tenths_r,  hunds_r;
   logic [3:0] tensNext_s, unitsNext_s, tenthsNext_s, hundsNext_s;
   logic [3:0] seg1_r;

   assign btnRaw_s = {btnClr, btnRun};
   assign runP_s   = pulse_r[0];
   assign clrP_s   = pulse_r[1];

   // Synchronise, debounce and edge-detect both buttons. The press pulse is
   // registered on the same edge as the level flip, so the FSM reacts on the
   // following edge.
   always_ff @(posedge CLK) begin
      if (RST) begin
         sync1_r    <= 2'b00;
         sync2_r    <= 2'b00;
         accLevel_r <= 2'b00;
         pulse_r    <= 2'b00;
         dbCnt_r[0] <= '0;
         dbCnt_r[1] <= '0;
      end else begin
         sync1_r <= btnRaw_s;
         sync2_r <= sync1_r;
         for (int i = 0; i < 2; i++) begin
            if (sync2_r[i] == accLevel_r[i]) begin
               dbCnt_r[i] <= '0;
               pulse_r[i] <= 1'b0;
            end else if (dbCnt_r[i] == DB_MAX) begin
               dbCnt_r[i]    <= '0;
               accLevel_r[i] <= sync2_r[i];
               pulse_r[i]    <= sync2_r[i];   // presses only, releases give no pulse
            end else begin
               dbCnt_r[i] <= dbCnt_r[i] + DB_W'(1);
               pulse_r[i] <= 1'b0;
            end
         end
      end
   end

   assign tick_s = (state_r == RUN) && (presc_r == PS_MAX);
   // Clear is honoured outside RUN only; in RUN a clear press is ignored.
   assign zero_s = clrP_s && (state_r != RUN);

   // BCD cascade: next digit values for a clear or a tick.
   always_comb begin
      tensNext_s   = tens_r;
      unitsNext_s  = units_r;
      tenthsNext_s = tenths_r;
      hundsNext_s  = hunds_r;
      wrap_s       = 1'b0;
      if (zero_s) begin
         tensNext_s   = 4'd0;
         unitsNext_s  = 4'd0;
         tenthsNext_s = 4'd0;
         hundsNext_s  = 4'd0;
      end else if (tick_s) begin
         // Any value of 9 or above wraps, so a corrupted digit cannot run past 9.
         if (hunds_r >= 4'd9) begin
            hundsNext_s = 4'd0;
            if (tenths_r >= 4'd9) begin
               tenthsNext_s = 4'd0;
               if (units_r >= 4'd9) begin
                  unitsNext_s = 4'd0;
                  if (tens_r >= 4'd9) begin
                     tensNext_s = 4'd0;
                     wrap_s     = 1'b1;
                  end else begin
                     tensNext_s = tens_r + 4'd1;
                  end
               end else begin
                  unitsNext_s = units_r + 4'd1;
               end
            end else begin
               tenthsNext_s = tenths_r + 4'd1;
            end
         end else begin
            hundsNext_s = hunds_r + 4'd1;
         end
      end else begin
         wrap_s = 1'b0;
      end
   end

   // Digit registers and the registered (possibly blanked) tens display code.
   always_ff @(posedge CLK) begin
      if (RST) begin
         tens_r   <= 4'd0;
         units_r  <= 4'd0;
         tenths_r <= 4'd0;
         hunds_r  <= 4'd0;
         seg1_r   <= RST_SEG1;
      end else begin
         tens_r   <= tensNext_s;
         units_r  <= unitsNext_s;
         tenths_r <= tenthsNext_s;
         hunds_r  <= hundsNext_s;
         seg1_r   <= (BLANK_LZ && (tensNext_s == 4'd0)) ? BLANK_CODE : tensNext_s;
      end
   end

   // Control FSM with prescaler and sticky overflow flag.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_r <= IDLE;
         presc_r <= '0;
         ovf_r   <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               presc_r <= '0;
               if (clrP_s) begin
                  state_r <= IDLE;
                  ovf_r   <= 1'b0;
               end else if (runP_s) begin
                  state_r <= RUN;
               end else begin
                  state_r <= IDLE;
               end
            end
            RUN: begin
               presc_r <= tick_s ? '0 : (presc_r + PS_W'(1));
               if (wrap_s) begin
                  ovf_r <= 1'b1;
               end else begin
                  ovf_r <= ovf_r;
               end
               state_r <= runP_s ? PAUSE : RUN;
            end
            PAUSE: begin
               // Prescaler holds so a resumed run keeps its phase.
               if (clrP_s) begin
                  state_r <= IDLE;
                  presc_r <= '0;
                  ovf_r   <= 1'b0;
               end else if (runP_s) begin
                  state_r <= RUN;
               end else begin
                  state_r <= PAUSE;
               end
            end
            default: begin
               state_r <= IDLE;
               presc_r <= '0;
               ovf_r   <= 1'b0;
            end
         endcase
      end
   end

   assign running   = (state_r == RUN);
   assign ovf       = ovf_r;
   assign segData_1 = seg1_r;
   assign segData_2 = units_r;
   assign segData_3 = tenths_r;
   assign segData_4 = hunds_r;

endmodule

// File: tb/tb_stopwatch_bcd.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_bcd
// Directed bench for stopwatch_bcd with CLK_DIV=4 and DEBOUNCE=3. Two instances
// share all inputs: dut0 with BLANK_LZ=1 and dut1 with BLANK_LZ=0. Stimulus
// pushes expected output snapshots into a queue; a monitor on the falling edge
// pops and compares them.
// -----------------------------------------------------------------------------
module tb_stopwatch_bcd;

   logic CLK = 1'b0;
   logic RST, btnRun, btnClr;
   logic [3:0] a1, a2, a3, a4, b1, b2, b3, b4;
   logic aRun, aOvf, bRun, bOvf;

   localparam int MAX_CYCLES = 50000;

   stopwatch_bcd #(.CLK_DIV(4), .DEBOUNCE(3), .BLANK_LZ(1'b1)) dut0 (
      .CLK(CLK), .RST(RST), .btnRun(btnRun), .btnClr(btnClr),
      .segData_1(a1), .segData_2(a2), .segData_3(a3), .segData_4(a4),
      .running(aRun), .ovf(aOvf)
   );

   stopwatch_bcd #(.CLK_DIV(4), .DEBOUNCE(3), .BLANK_LZ(1'b0)) dut1 (
      .CLK(CLK), .RST(RST), .btnRun(btnRun), .btnClr(btnClr),
      .segData_1(b1), .segData_2(b2), .segData_3(b3), .segData_4(b4),
      .running(bRun), .ovf(bOvf)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      string      name;
      int         inst;
      logic [17:0] val;   // {d1, d2, d3, d4, running, ovf}
   } exp_t;

   exp_t expQ[$];
   int   nChecks = 0;
   int   nPass   = 0;
   int   cycN    = 0;
   int   e0, r0, w0, s0, t0;

   task automatic cyc();
      @(posedge CLK);
      #1;
      cycN++;
   endtask

   task automatic runTo(input int n);
      while (cycN < n) cyc();
   endtask

   task automatic push(input string nm, input int inst,
                       input logic [3:0] d1, input logic [3:0] d2,
                       input logic [3:0] d3, input logic [3:0] d4,
                       input logic r, input logic o);
      exp_t e;
      e.name = nm;
      e.inst = inst;
      e.val  = {d1, d2, d3, d4, r, o};
      expQ.push_back(e);
   endtask

   // Watchdog: abort if the run exceeds the expected cycle budget.
   always @(posedge CLK) begin
      if (cycN > MAX_CYCLES) begin
         $display("FAIL watchdog: wait expired after %0d cycles", cycN);
         $finish;
      end
   end

   // Monitor: compare every pending expectation against the live outputs.
   always @(negedge CLK) begin
      exp_t e;
      logic [17:0] act;
      while (expQ.size() > 0) begin
         e   = expQ.pop_front();
         act = (e.inst == 0) ? {a1, a2, a3, a4, aRun, aOvf}
                             : {b1, b2, b3, b4, bRun, bOvf};
         nChecks++;
         if (act == e.val) begin
            nPass++;
         end else begin
            $display("FAIL %s (dut%0d): got digits %0d,%0d,%0d,%0d run=%0b ovf=%0b, expected %0d,%0d,%0d,%0d run=%0b ovf=%0b",
                     e.name, e.inst, act[17:14], act[13:10], act[9:6], act[5:2], act[1], act[0],
                     e.val[17:14], e.val[13:10], e.val[9:6], e.val[5:2], e.val[1], e.val[0]);
         end
      end
   end

   initial begin
      RST = 1'b1; btnRun = 1'b0; btnClr = 1'b0;
      cyc(); cyc();
      nChecks++;
      if ({a1, a2, a3, a4, aRun, aOvf} === {4'd12, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0} &&
          {b1, b2, b3, b4, bRun, bOvf} === {4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0}) begin
         nPass++;
      end else begin
         $display("FAIL reset_state: dut0 %0d,%0d,%0d,%0d run=%0b ovf=%0b dut1 %0d,%0d,%0d,%0d run=%0b ovf=%0b",
                  a1, a2, a3, a4, aRun, aOvf, b1, b2, b3, b4, bRun, bOvf);
      end
      push("reset_blank", 0, 4'd12, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
      push("reset_noblank", 1, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
      RST = 1'b0;

      // Bounce: 2-cycle pulses never satisfy a 3-cycle debounce.
      for (int i = 0; i < 5; i++) begin
         btnRun = 1'b1; cyc(); cyc();
         btnRun = 1'b0; cyc(); cyc();
         push("bounce", 0, 4'd12, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
      end
      repeat (6) cyc();
      push("bounce_settled", 0, 4'd12, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);

      // Clean press: state changes exactly 6 cycles after the rise.
      btnRun = 1'b1;
      repeat (5) cyc();
      push("start_5cyc", 0, 4'd12, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
      cyc();
      push("start_6cyc", 0, 4'd12, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0);
      btnRun = 1'b0;
      e0 = cycN;

      runTo(e0 + 39);
      push("count_9", 0, 4'd12, 4'd0, 4'd0, 4'd9, 1'b1, 1'b0);
      cyc();
      push("count_10", 0, 4'd12, 4'd0, 4'd1, 4'd0, 1'b1, 1'b0);

      // Clear while running is ignored.
      btnClr = 1'b1;
      runTo(e0 + 46);
      btnClr = 1'b0;
      runTo(e0 + 47);
      push("clr_in_run", 0, 4'd12, 4'd0, 4'd1, 4'd1, 1'b1, 1'b0);

      // Pause at 00.37 (prescaler left at 2).
      runTo(e0 + 144);
      btnRun = 1'b1;
      runTo(e0 + 149);
      push("pre_pause", 0, 4'd12, 4'd0, 4'd3, 4'd7, 1'b1, 1'b0);
      cyc();
      push("pause", 0, 4'd12, 4'd0, 4'd3, 4'd7, 1'b0, 1'b0);
      btnRun = 1'b0;
      runTo(e0 + 160);
      push("frozen", 0, 4'd12, 4'd0, 4'd3, 4'd7, 1'b0, 1'b0);

      // Resume: prescaler continues from 2, so the next tick is 2 cycles later.
      btnRun = 1'b1;
      runTo(e0 + 166);
      r0 = cycN;
      push("resume", 0, 4'd12, 4'd0, 4'd3, 4'd7, 1'b1, 1'b0);
      btnRun = 1'b0;
      cyc();
      push("resume_p1", 0, 4'd12, 4'd0, 4'd3, 4'd7, 1'b1, 1'b0);
      cyc();
      push("resume_tick", 0, 4'd12, 4'd0, 4'd3, 4'd8, 1'b1, 1'b0);

      // Pause again at 00.41, then clear.
      runTo(r0 + 10);
      btnRun = 1'b1;
      runTo(r0 + 16);
      push("pause2", 0, 4'd12, 4'd0, 4'd4, 4'd1, 1'b0, 1'b0);
      btnRun = 1'b0;
      cyc();
      btnClr = 1'b1;
      runTo(r0 + 22);
      push("pre_clear", 0, 4'd12, 4'd0, 4'd4, 4'd1, 1'b0, 1'b0);
      cyc();
      push("clear", 0, 4'd12, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
      btnClr = 1'b0;

      // Wrap: 10000 ticks from zero.
      cyc();
      btnRun = 1'b1;
      runTo(r0 + 30);
      w0 = cycN;
      push("run_from_zero", 0, 4'd12, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0);
      btnRun = 1'b0;
      runTo(w0 + 39999);
      push("at_9999", 0, 4'd9, 4'd9, 4'd9, 4'd9, 1'b1, 1'b0);
      cyc();
      push("wrap", 0, 4'd12, 4'd0, 4'd0, 4'd0, 1'b1, 1'b1);
      push("wrap_noblank", 1, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b1);
      runTo(w0 + 44000);
      push("after_1000", 0, 4'd1, 4'd0, 4'd0, 4'd0, 1'b1, 1'b1);
      push("after_1000_nb", 1, 4'd1, 4'd0, 4'd0, 4'd0, 1'b1, 1'b1);

      // Both buttons together in RUN: pause, time kept.
      btnRun = 1'b1; btnClr = 1'b1;
      runTo(w0 + 44006);
      s0 = cycN;
      push("both_in_run", 0, 4'd1, 4'd0, 4'd0, 4'd1, 1'b0, 1'b1);
      btnRun = 1'b0; btnClr = 1'b0;
      runTo(s0 + 5);
      push("both_paused", 0, 4'd1, 4'd0, 4'd0, 4'd1, 1'b0, 1'b1);

      // Both buttons together in PAUSE: clear wins, ovf clears.
      cyc();
      btnRun = 1'b1; btnClr = 1'b1;
      runTo(s0 + 11);
      push("pre_both_pause", 0, 4'd1, 4'd0, 4'd0, 4'd1, 1'b0, 1'b1);
      cyc();
      push("both_in_pause", 0, 4'd12, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
      push("both_in_pause_nb", 1, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
      btnRun = 1'b0; btnClr = 1'b0;

      // Reset coincident with the second tick.
      runTo(s0 + 18);
      btnRun = 1'b1;
      runTo(s0 + 24);
      t0 = cycN;
      btnRun = 1'b0;
      runTo(t0 + 7);
      push("pre_rst_tick", 0, 4'd12, 4'd0, 4'd0, 4'd1, 1'b1, 1'b0);
      RST = 1'b1;
      cyc();
      push("rst_on_tick", 0, 4'd12, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
      RST = 1'b0;
      runTo(t0 + 20);
      push("idle_after_rst", 0, 4'd12, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);

      @(negedge CLK);
      #1;
      $display("%0d/%0d checks passed", nPass, nChecks);
      if (nPass == nChecks && expQ.size() == 0) begin
         $display("PASS");
      end else begin
         $display("FAIL");
      end
      $finish;
   end

endmodule
